mc_adr_gen: RTL and testbench

Parametrised SDRAM address generator for the memory controller, next generation of the address-select path. It latches row, bank and column from the Wishbone address using programmable field widths instead of a fixed size table. It advances the column through a burst with sequential wrap and tracks the open row in every bank to flag page hits. It drives the multiplexed SDRAM address bus for ACT/RD/WR/PRE/LMR/REF.

---
 rtl/mc_adr_gen.sv | 156 +++++++++++++++
 tb/tb_mc_adr_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_adr_gen.sv
// mc_adr_gen: parametrised SDRAM address generator (field extraction, burst column, open-row tracking, A-bus mux).
// Define MC_ADR_BANK_TRACK_EN to build the per-bank open-row table; otherwise page_hit is tied low.
module mc_adr_gen #(
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned COL_W     = 11,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned ADR_OUT_W = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 wb_addr_i,
  input  logic [1:0]                  bus_width,
  input  logic [3:0]                  col_bits,
  input  logic [3:0]                  row_bits,
  input  logic                        bas,
  input  logic [2:0]                  burst_len,
  input  logic                        cs_le,
  input  logic                        next_adr,
  input  logic                        act,
  input  logic                        pre,
  input  logic                        rfr_ack,
  input  logic                        cmd_a10,
  input  logic                        row_sel,
  input  logic                        lmr_sel,
  input  logic                        cas_,
  input  logic [ADR_OUT_W-1:0]        tms,
  output logic [ADR_OUT_W+BANK_W-1:0] mc_addr,
  output logic [ROW_W-1:0]            row_adr,
  output logic [COL_W-1:0]            col_adr,
  output logic [BANK_W-1:0]           bank_adr,
  output logic                        page_hit,
  output logic                        burst_last,
  output logic [COL_W:0]              page_size
);

  localparam int unsigned BANKS = 1 << BANK_W;
  localparam int unsigned PS_W  = COL_W + 1;
  localparam logic [31:0] BMASK = 32'(BANKS - 1);

  logic [3:0]           cb, rb;
  logic [1:0]           sh;
  logic [31:0]          w, cmask, rmask;
  logic [COL_W-1:0]     col_f;
  logic [BANK_W-1:0]    bank_f;
  logic [ROW_W-1:0]     row_f;
  logic [COL_W-1:0]     cnt, bl_m1;
  logic [ADR_OUT_W-1:0] a, col_ext;

  // Clamp programmed field widths into the supported ranges
  always_comb begin
    cb = col_bits;
    if (col_bits < 4'd8) cb = 4'd8;
    else if (col_bits > 4'(COL_W)) cb = 4'(COL_W);
    rb = row_bits;
    if (row_bits < 4'd11) rb = 4'd11;
    else if (row_bits > 4'(ROW_W)) rb = 4'(ROW_W);
  end

  // Split the word address into column, bank and row
  always_comb begin
    sh     = (bus_width == 2'd3) ? 2'd2 : bus_width;
    w      = wb_addr_i >> sh;
    cmask  = (32'd1 << cb) - 32'd1;
    rmask  = (32'd1 << rb) - 32'd1;
    col_f  = COL_W'(w & cmask);
    bank_f = '0;
    row_f  = '0;
    if (!bas) begin
      bank_f = BANK_W'((w >> cb) & BMASK);
      row_f  = ROW_W'((w >> (32'(cb) + 32'(BANK_W))) & rmask);
    end else begin
      row_f  = ROW_W'((w >> cb) & rmask);
      bank_f = BANK_W'((w >> (32'(cb) + 32'(rb))) & BMASK);
    end
  end

  // Burst length minus one; doubles as the wrap mask for the column
  always_comb begin
    bl_m1 = '0;
    case (burst_len)
      3'd1:    bl_m1 = COL_W'(1);
      3'd2:    bl_m1 = COL_W'(3);
      3'd3:    bl_m1 = COL_W'(7);
      3'd7:    bl_m1 = (COL_W'(1) << cb) - COL_W'(1);
      default: bl_m1 = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_adr  <= '0;
      row_adr  <= '0;
      bank_adr <= '0;
      cnt      <= '0;
    end else if (cs_le) begin
      col_adr  <= col_f;
      row_adr  <= row_f;
      bank_adr <= bank_f;
      cnt      <= '0;
    end else if (next_adr) begin
      col_adr <= (col_adr & ~bl_m1) | ((col_adr + COL_W'(1)) & bl_m1);
      cnt     <= (cnt >= bl_m1) ? '0 : cnt + COL_W'(1);
    end
  end

  assign burst_last = (cnt == bl_m1);
  assign page_size  = PS_W'(1) << cb;

`ifdef MC_ADR_BANK_TRACK_EN
  logic [ROW_W-1:0] open_row [BANKS];
  logic [BANKS-1:0] valid, valid_nxt;

  // Closes happen before opens so an ACT in the same cycle keeps its bank open
  always_comb begin
    valid_nxt = valid;
    if (rfr_ack || (pre && cmd_a10)) valid_nxt = '0;
    else if (pre) valid_nxt[bank_adr] = 1'b0;
    if (act) valid_nxt[bank_adr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < int'(BANKS); i++) open_row[i] <= '0;
    end else begin
      valid <= valid_nxt;
      if (act) open_row[bank_adr] <= row_adr;
    end
  end

  assign page_hit = valid[bank_adr] && (open_row[bank_adr] == row_adr);
`else
  logic unused_trk;
  assign unused_trk = act | pre;
  assign page_hit   = 1'b0;
`endif

  // A-bus mux: column skips A10, which carries the auto-precharge / all-banks flag
  always_comb begin
    a       = '0;
    col_ext = ADR_OUT_W'(col_adr);
    if (lmr_sel && !cas_) begin
      a = tms;
    end else if (row_sel) begin
      a = ADR_OUT_W'(row_adr);
    end else begin
      for (int i = 0; i < 10; i++) a[i] = col_ext[i];
      a[10] = cmd_a10;
      for (int i = 11; i < int'(ADR_OUT_W); i++) a[i] = col_ext[i-1];
    end
    if (rfr_ack) a[10] = 1'b1;
  end

  assign mc_addr = {bank_adr, a};

endmodule

// File: tb/tb_mc_adr_gen.sv
// Self-checking bench for mc_adr_gen: directed literals plus randomized traffic against a behavioural model.
// Follows MC_ADR_BANK_TRACK_EN the same way the design does.
module tb_mc_adr_gen;

  localparam int unsigned ROW_W     = 13;
  localparam int unsigned COL_W     = 11;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned ADR_OUT_W = 13;
`ifdef MC_ADR_BANK_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [31:0]                 wb_addr_i;
  logic [1:0]                  bus_width;
  logic [3:0]                  col_bits, row_bits;
  logic                        bas;
  logic [2:0]                  burst_len;
  logic                        cs_le, next_adr, act, pre, rfr_ack, cmd_a10, row_sel, lmr_sel, cas_;
  logic [ADR_OUT_W-1:0]        tms;
  logic [ADR_OUT_W+BANK_W-1:0] mc_addr;
  logic [ROW_W-1:0]            row_adr;
  logic [COL_W-1:0]            col_adr;
  logic [BANK_W-1:0]           bank_adr;
  logic                        page_hit, burst_last;
  logic [COL_W:0]              page_size;

  mc_adr_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .ADR_OUT_W(ADR_OUT_W)) dut (
    .clk(clk), .rst(rst), .wb_addr_i(wb_addr_i), .bus_width(bus_width), .col_bits(col_bits),
    .row_bits(row_bits), .bas(bas), .burst_len(burst_len), .cs_le(cs_le), .next_adr(next_adr),
    .act(act), .pre(pre), .rfr_ack(rfr_ack), .cmd_a10(cmd_a10), .row_sel(row_sel),
    .lmr_sel(lmr_sel), .cas_(cas_), .tms(tms), .mc_addr(mc_addr), .row_adr(row_adr),
    .col_adr(col_adr), .bank_adr(bank_adr), .page_hit(page_hit), .burst_last(burst_last),
    .page_size(page_size)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int unsigned m_col, m_row, m_bank, m_cnt;
  bit          m_valid [4];
  int unsigned m_open  [4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned v, input int unsigned lo, input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int unsigned bl_of(input int unsigned bl, input int unsigned cbits);
    case (bl)
      1: return 2;
      2: return 4;
      3: return 8;
      7: return 1 << cbits;
      default: return 1;
    endcase
  endfunction

  task automatic model_clear();
    m_col = 0; m_row = 0; m_bank = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_open[i]  = 0;
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs held across that edge
  task automatic model_step();
    int unsigned cbits, rbits, bl, w, off;
    if (rst) begin
      model_clear();
      return;
    end
    cbits = clamp(32'(col_bits), 8, COL_W);
    rbits = clamp(32'(row_bits), 11, ROW_W);
    bl    = bl_of(32'(burst_len), cbits);
    if (TRK) begin
      if (rfr_ack || (pre && cmd_a10)) for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
      else if (pre) m_valid[m_bank] = 1'b0;
      if (act) begin
        m_valid[m_bank] = 1'b1;
        m_open[m_bank]  = m_row;
      end
    end
    if (cs_le) begin
      w = wb_addr_i / (bus_width == 2'd0 ? 1 : bus_width == 2'd1 ? 2 : 4);
      m_col = w % (1 << cbits);
      if (!bas) begin
        m_bank = (w >> cbits) % 4;
        m_row  = (w >> (cbits + 2)) % (1 << rbits);
      end else begin
        m_row  = (w >> cbits) % (1 << rbits);
        m_bank = (w >> (cbits + rbits)) % 4;
      end
      m_cnt = 0;
    end else if (next_adr) begin
      off   = m_col % bl;
      m_col = m_col - off + (off + 1) % bl;
      m_cnt = (m_cnt + 1) % bl;
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : cmp
    int unsigned cbits, bl, a;
    bit          hit;
    if (chk_en && !rst) begin
      cbits = clamp(32'(col_bits), 8, COL_W);
      bl    = bl_of(32'(burst_len), cbits);
      hit   = TRK && m_valid[m_bank] && (m_open[m_bank] == m_row);
      if (lmr_sel && !cas_) a = 32'(tms);
      else if (row_sel) a = m_row;
      else a = (m_col % 1024) + (cmd_a10 ? 1024 : 0) + (m_col / 1024) * 2048;
      if (rfr_ack) a = a | 1024;
      a = a % 8192;
      check("col_adr", 64'(col_adr), 64'(m_col));
      check("row_adr", 64'(row_adr), 64'(m_row));
      check("bank_adr", 64'(bank_adr), 64'(m_bank));
      check("burst_last", 64'(burst_last), 64'(m_cnt == bl - 1));
      check("page_hit", 64'(page_hit), 64'(hit));
      check("mc_addr", 64'(mc_addr), 64'(m_bank * 8192 + a));
      check("page_size", 64'(page_size), 64'(1 << cbits));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [ADR_OUT_W-1:0] a_lo;
    rst = 1'b1; wb_addr_i = '0; bus_width = 2'd0; col_bits = 4'd9; row_bits = 4'd13; bas = 1'b0;
    burst_len = 3'd2; cs_le = 1'b0; next_adr = 1'b0; act = 1'b0; pre = 1'b0; rfr_ack = 1'b0;
    cmd_a10 = 1'b0; row_sel = 1'b0; lmr_sel = 1'b0; cas_ = 1'b1; tms = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset col", 64'(col_adr), 64'h0);
    check("reset row", 64'(row_adr), 64'h0);
    check("reset bank", 64'(bank_adr), 64'h0);
    check("reset page_hit", 64'(page_hit), 64'h0);
    check("reset burst_last", 64'(burst_last), 64'h0);

    // Field extraction, 32-bit bus
    bus_width = 2'd2; wb_addr_i = 32'h0012_3458; cs_le = 1'b1;
    tick();
    cs_le = 1'b0;
    check("latch col", 64'(col_adr), 64'h116);
    check("latch bank", 64'(bank_adr), 64'h2);
    check("latch row", 64'(row_adr), 64'h091);
    check("latch page_size", 64'(page_size), 64'd512);
    check("model col", 64'(m_col), 64'h116);
    check("model row", 64'(m_row), 64'h091);

    // BL4 sequential wrap
    bus_width = 2'd0; wb_addr_i = 32'h006; cs_le = 1'b1;
    tick();
    cs_le = 1'b0; next_adr = 1'b1;
    tick(); check("bl4 beat1", 64'(col_adr), 64'h007);
    tick(); check("bl4 beat2", 64'(col_adr), 64'h004);
    tick(); check("bl4 beat3", 64'(col_adr), 64'h005);
    check("bl4 last", 64'(burst_last), 64'h1);
    check("model cnt", 64'(m_cnt), 64'd3);
    tick(); check("bl4 beat4", 64'(col_adr), 64'h006);
    check("bl4 wrap last", 64'(burst_last), 64'h0);
    next_adr = 1'b0;

    // Full page at 8 column bits
    col_bits = 4'd8; burst_len = 3'd7; wb_addr_i = 32'h0FE; cs_le = 1'b1;
    tick();
    cs_le = 1'b0; next_adr = 1'b1;
    check("fp page_size", 64'(page_size), 64'd256);
    tick(); check("fp beat1", 64'(col_adr), 64'h0FF);
    tick(); check("fp beat2", 64'(col_adr), 64'h000);
    next_adr = 1'b0;

    // Open-row tracking: bank 1 row 0x0AB
    wb_addr_i = 32'h0002_AD00; cs_le = 1'b1;
    tick();
    cs_le = 1'b0;
    check("pg bank", 64'(bank_adr), 64'h1);
    check("pg row", 64'(row_adr), 64'h0AB);
    act = 1'b1; tick(); act = 1'b0;
    cs_le = 1'b1; tick(); cs_le = 1'b0;
    check("hit relatch", 64'(page_hit), 64'(TRK));
    pre = 1'b1; cmd_a10 = 1'b0; tick(); pre = 1'b0;
    check("hit after pre", 64'(page_hit), 64'h0);
    act = 1'b1; tick(); act = 1'b0;
    check("hit after act", 64'(page_hit), 64'(TRK));
    rfr_ack = 1'b1; tick();
    check("hit after rfr", 64'(page_hit), 64'h0);
    check("rfr a10", 64'(mc_addr), 64'h2400);
    rfr_ack = 1'b0;

    // cs_le beats next_adr, then async reset mid-burst
    col_bits = 4'd9; burst_len = 3'd2; wb_addr_i = 32'h006; cs_le = 1'b1;
    tick();
    cs_le = 1'b0; next_adr = 1'b1;
    tick();
    wb_addr_i = 32'h0000_8A0A; cs_le = 1'b1;
    tick();
    cs_le = 1'b0;
    check("prio col", 64'(col_adr), 64'h00A);
    check("prio bank", 64'(bank_adr), 64'h1);
    check("prio row", 64'(row_adr), 64'h011);
    check("prio cnt", 64'(burst_last), 64'h0);
    tick();
    next_adr = 1'b0; rst = 1'b1; model_clear();
    #1;
    check("async col", 64'(col_adr), 64'h0);
    check("async row", 64'(row_adr), 64'h0);
    check("async bank", 64'(bank_adr), 64'h0);
    check("async last", 64'(burst_last), 64'h0);
    tick();
    rst = 1'b0;

    // Mode register and column A-bus layout
    lmr_sel = 1'b1; cas_ = 1'b0; tms = 13'h0233;
    #1;
    a_lo = mc_addr[ADR_OUT_W-1:0];
    check("lmr tms", 64'(a_lo), 64'h0233);
    lmr_sel = 1'b0; cas_ = 1'b1;
    col_bits = 4'd11; burst_len = 3'd0; wb_addr_i = 32'h5A3; cs_le = 1'b1;
    tick();
    cs_le = 1'b0; cmd_a10 = 1'b1; row_sel = 1'b0;
    #1;
    check("col abus", 64'(mc_addr), 64'h0DA3);
    check("bl1 last", 64'(burst_last), 64'h1);
    cmd_a10 = 1'b0;

    // Randomized traffic; burst config only changes together with a new latch
    for (int n = 0; n < 800; n++) begin
      wb_addr_i = $urandom;
      bus_width = 2'($urandom_range(0, 3));
      row_bits  = 4'($urandom_range(11, 15));
      bas       = 1'($urandom_range(0, 1));
      cs_le     = ($urandom_range(0, 7) == 0);
      if (cs_le && $urandom_range(0, 1) == 1) begin
        col_bits  = 4'($urandom_range(8, 15));
        burst_len = 3'($urandom_range(0, 7));
      end
      next_adr = ($urandom_range(0, 1) == 1);
      act      = ($urandom_range(0, 5) == 0);
      pre      = ($urandom_range(0, 7) == 0);
      rfr_ack  = ($urandom_range(0, 11) == 0);
      cmd_a10  = 1'($urandom_range(0, 1));
      row_sel  = 1'($urandom_range(0, 1));
      lmr_sel  = ($urandom_range(0, 3) == 0);
      cas_     = 1'($urandom_range(0, 1));
      tms      = 13'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
